tbird_tail_lights: RTL and testbench
====================================

TBIRD_TAIL_LIGHTS -- requirements
Module: tbird_tail_lights

Interface
REQ-001 The block SHALL have no parameters; all timing is one state per Clock cycle.
REQ-002 Clock  input  1  sole clock; all state changes on rising edge.
REQ-003 Clear  input  1  synchronous, active-high reset; sampled on rising Clock.
REQ-004 Left  input  1  left-turn request, level-sensitive, sampled on rising Clock.
REQ-005 Right  input  1  right-turn request, level-sensitive, sampled on rising Clock.
REQ-006 Hazard  input  1  hazard request, level-sensitive, sampled on rising Clock.
REQ-007 LA, LB, LC  output  1 each  left lamps, inner (LA) to outer (LC); 1 = lit.
REQ-008 RA, RB, RC  output  1 each  right lamps, inner (RA) to outer (RC); 1 = lit.
REQ-009 Port order SHALL be Clock, Clear, Left, Right, Hazard, LA, LB, LC, RA, RB, RC; one clock, reset synchronous and active-high.

Function
REQ-010 The block SHALL be a Moore FSM with 8 states: IDLE, L1, L2, L3, R1, R2, R3, LR3.
REQ-011 Outputs SHALL decode from the state register only: IDLE all 0; L1 LA; L2 LA,LB; L3 LA,LB,LC; R1 RA; R2 RA,RB; R3 RA,RB,RC; LR3 all six = 1; unused lamps 0.
REQ-012 IDLE transitions, in priority order: Hazard=1 -> LR3; Left=1 and Right=1 -> LR3; Left=1 -> L1; Right=1 -> R1; else IDLE.
REQ-013 L1 -> LR3 if Hazard=1, else L2; L2 -> LR3 if Hazard=1, else L3; L3 -> IDLE unconditionally.
REQ-014 R1 -> LR3 if Hazard=1, else R2; R2 -> LR3 if Hazard=1, else R3; R3 -> IDLE unconditionally.
REQ-015 LR3 -> IDLE unconditionally.
REQ-016 Once started, a left/right sequence SHALL run to L3/R3 regardless of Left/Right deasserting or the opposite direction asserting; only Hazard aborts it, and only from L1, L2, R1, R2.
REQ-017 Held Left (no Hazard) SHALL repeat IDLE,L1,L2,L3 with period 4 cycles; held Right likewise with R states; held Hazard SHALL alternate LR3,IDLE with period 2.
REQ-018 Any unreachable encoding SHALL transition to IDLE on the next edge and drive all lamps 0.
REQ-019 X or undefined inputs while Clear=1 SHALL NOT affect state.

Reset
REQ-020 Clear=1 on a rising edge SHALL force IDLE on that edge from any state, overriding all inputs; all outputs 0 from that edge onward.
REQ-021 Clear asserted mid-sequence (e.g. in L2) SHALL abort it; no residual lamp stays lit.
REQ-022 First transition after Clear deasserts SHALL follow REQ-012 from IDLE.
REQ-023 No asynchronous reset path SHALL exist.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE, L1, L2, L3, R1, R2, R3, LR3) and a 6-bit lamp-pattern constant per state ordered {LC,LB,LA,RA,RB,RC}.
REQ-025 The block SHALL be a single module: state register, next-state logic, output decode; no sub-module.

Verification
REQ-026 Clear=1 two cycles, inputs 000 -> all lamps 0 and state IDLE after first edge and while inputs stay 000.
REQ-027 After reset, {Left,Right,Hazard}=100 for 6 cycles -> LA;LA,LB;LA,LB,LC;off;LA;LA,LB; right lamps 0 throughout; then 000 -> completes current sequence, returns to off.
REQ-028 {L,R,H}=001 held 6 cycles -> all six on, all off, alternating each cycle; 011 (Right+Hazard) from IDLE -> same LR3 pattern.
REQ-029 100 one cycle then 101 -> L1 (LA) then LR3 (all on), then alternating off/all-on; same with 010/011 from R1.
REQ-030 100 two cycles then 101 -> L1, L2 (LA,LB), LR3; 100 three cycles then 101 -> L1, L2, L3, IDLE (L3 ignores Hazard), then LR3; mirror for right.
REQ-031 Clear=1 asserted while in L2 -> next edge all lamps 0 and held 0 while Clear=1, regardless of Left/Hazard.

Source files
------------

// File: rtl/tbird_tail_lights_pkg.sv
// Shared definitions for the Thunderbird tail-light sequencer: the state
// encoding and the lamp pattern each state shows.
package tbird_tail_lights_pkg;

    // One state per clock; all eight 3-bit encodings are used.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        LR3  = 3'd7
    } state_e;

    // Lamp patterns ordered {LC,LB,LA,RA,RB,RC}. The left lamps light
    // from the inside out, and so do the right lamps.
    localparam logic [5:0] LAMPS_IDLE = 6'b000_000;
    localparam logic [5:0] LAMPS_L1   = 6'b001_000;
    localparam logic [5:0] LAMPS_L2   = 6'b011_000;
    localparam logic [5:0] LAMPS_L3   = 6'b111_000;
    localparam logic [5:0] LAMPS_R1   = 6'b000_100;
    localparam logic [5:0] LAMPS_R2   = 6'b000_110;
    localparam logic [5:0] LAMPS_R3   = 6'b000_111;
    localparam logic [5:0] LAMPS_LR3  = 6'b111_111;

    // Moore output decode. The default arm keeps every lamp off for any
    // encoding that is not listed.
    function automatic logic [5:0] lamp_pattern(input state_e state);
        logic [5:0] lamps;
        lamps = LAMPS_IDLE;
        case (state)
            IDLE:    lamps = LAMPS_IDLE;
            L1:      lamps = LAMPS_L1;
            L2:      lamps = LAMPS_L2;
            L3:      lamps = LAMPS_L3;
            R1:      lamps = LAMPS_R1;
            R2:      lamps = LAMPS_R2;
            R3:      lamps = LAMPS_R3;
            LR3:     lamps = LAMPS_LR3;
            default: lamps = LAMPS_IDLE;
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/tbird_tail_lights.sv
// Thunderbird tail-light sequencer. This is a Moore FSM: the left and right
// sequences walk three lamps outward, and Hazard flashes all six lamps.
module tbird_tail_lights
    import tbird_tail_lights_pkg::*;
(
    input  logic Clock,
    input  logic Clear,
    input  logic Left,
    input  logic Right,
    input  logic Hazard,
    output logic LA,
    output logic LB,
    output logic LC,
    output logic RA,
    output logic RB,
    output logic RC
);

    state_e     state_q;
    state_e     state_d;
    logic [5:0] lamps;

    // State register. Clear is synchronous and takes priority over the
    // next-state logic, so the inputs cannot disturb the state while Clear
    // is high.
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the values from before the edge.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A started turn sequence runs to L3/R3, and only
    // Hazard can abort it, from the first two steps.
    always_comb begin
        // NOTE: the default is assigned before the case, so no path leaves
        // state_d unassigned and no latch is inferred.
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (Hazard)              state_d = LR3;
                else if (Left && Right)  state_d = LR3;
                else if (Left)           state_d = L1;
                else if (Right)          state_d = R1;
                else                     state_d = IDLE;
            end
            L1:      state_d = Hazard ? LR3 : L2;
            L2:      state_d = Hazard ? LR3 : L3;
            L3:      state_d = IDLE;
            R1:      state_d = Hazard ? LR3 : R2;
            R2:      state_d = Hazard ? LR3 : R3;
            R3:      state_d = IDLE;
            LR3:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode, driven only from the state register.
    assign lamps = lamp_pattern(state_q);
    assign {LC, LB, LA, RA, RB, RC} = lamps;

endmodule

// File: tb/tb_tbird_tail_lights.sv
// Directed bench for tbird_tail_lights. Each step applies the inputs, lets
// one rising edge pass, and compares {LC,LB,LA,RA,RB,RC} with a pattern
// worked out by hand.
module tb_tbird_tail_lights;

    logic Clock;
    logic Clear;
    logic Left;
    logic Right;
    logic Hazard;
    logic LA, LB, LC, RA, RB, RC;

    int checks   = 0;
    int failures = 0;

    // Lamp patterns as the bench expects them, ordered {LC,LB,LA,RA,RB,RC}.
    localparam logic [5:0] OFF = 6'b000_000;
    localparam logic [5:0] EL1 = 6'b001_000;
    localparam logic [5:0] EL2 = 6'b011_000;
    localparam logic [5:0] EL3 = 6'b111_000;
    localparam logic [5:0] ER1 = 6'b000_100;
    localparam logic [5:0] ER2 = 6'b000_110;
    localparam logic [5:0] ER3 = 6'b000_111;
    localparam logic [5:0] ALL = 6'b111_111;

    tbird_tail_lights dut (
        .Clock  (Clock),
        .Clear  (Clear),
        .Left   (Left),
        .Right  (Right),
        .Hazard (Hazard),
        .LA     (LA),
        .LB     (LB),
        .LC     (LC),
        .RA     (RA),
        .RB     (RB),
        .RC     (RC)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Counts one comparison and reports it if the value differs.
    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got lamps %b, expected %b", tag, got, exp);
        end
    endtask

    // Applies {clr, l, r, h}, waits for one rising edge, then samples the
    // lamps 1 ns later.
    task automatic step(input string tag, input logic clr, input logic l,
                        input logic r, input logic h, input logic [5:0] exp);
        Clear  = clr;
        Left   = l;
        Right  = r;
        Hazard = h;
        @(posedge Clock);
        #1;
        check(tag, {LC, LB, LA, RA, RB, RC}, exp);
    endtask

    initial begin
        Clear = 1'b1; Left = 1'b0; Right = 1'b0; Hazard = 1'b0;

        // Reset for two cycles, then stay idle.
        step("rst_0",  1, 0, 0, 0, OFF);
        step("rst_1",  1, 0, 0, 0, OFF);
        step("idle_0", 0, 0, 0, 0, OFF);
        step("idle_1", 0, 0, 0, 0, OFF);

        // Left held for 6 cycles, then released while the sequence finishes.
        step("left_0", 0, 1, 0, 0, EL1);
        step("left_1", 0, 1, 0, 0, EL2);
        step("left_2", 0, 1, 0, 0, EL3);
        step("left_3", 0, 1, 0, 0, OFF);
        step("left_4", 0, 1, 0, 0, EL1);
        step("left_5", 0, 1, 0, 0, EL2);
        step("left_rel_0", 0, 0, 0, 0, EL3);
        step("left_rel_1", 0, 0, 0, 0, OFF);

        // Right held: one full period.
        step("right_0", 0, 0, 1, 0, ER1);
        step("right_1", 0, 0, 1, 0, ER2);
        step("right_2", 0, 0, 1, 0, ER3);
        step("right_3", 0, 0, 1, 0, OFF);
        step("right_idle", 0, 0, 0, 0, OFF);

        // Hazard held for 6 cycles: the lamps alternate all-on and all-off.
        for (int i = 0; i < 6; i++)
            step($sformatf("haz_%0d", i), 0, 0, 0, 1, (i % 2 == 0) ? ALL : OFF);
        step("haz_idle", 0, 0, 0, 0, OFF);

        // Right+Hazard from IDLE, then Left+Right from IDLE.
        step("rh_0", 0, 0, 1, 1, ALL);
        step("rh_1", 0, 0, 0, 0, OFF);
        step("lr_0", 0, 1, 1, 0, ALL);
        step("lr_1", 0, 0, 0, 0, OFF);

        // Hazard aborts from L1 and R1.
        step("abL1_0", 0, 1, 0, 0, EL1);
        step("abL1_1", 0, 1, 0, 1, ALL);
        step("abL1_2", 0, 1, 0, 1, OFF);
        step("abL1_3", 0, 1, 0, 1, ALL);
        step("abL1_4", 0, 0, 0, 0, OFF);
        step("abR1_0", 0, 0, 1, 0, ER1);
        step("abR1_1", 0, 0, 1, 1, ALL);
        step("abR1_2", 0, 0, 0, 0, OFF);

        // Hazard aborts from L2 and R2.
        step("abL2_0", 0, 1, 0, 0, EL1);
        step("abL2_1", 0, 1, 0, 0, EL2);
        step("abL2_2", 0, 1, 0, 1, ALL);
        step("abL2_3", 0, 0, 0, 0, OFF);
        step("abR2_0", 0, 0, 1, 0, ER1);
        step("abR2_1", 0, 0, 1, 0, ER2);
        step("abR2_2", 0, 0, 1, 1, ALL);
        step("abR2_3", 0, 0, 0, 0, OFF);

        // L3 and R3 ignore Hazard: they return to IDLE, and LR3 follows.
        step("L3h_0", 0, 1, 0, 0, EL1);
        step("L3h_1", 0, 1, 0, 0, EL2);
        step("L3h_2", 0, 1, 0, 0, EL3);
        step("L3h_3", 0, 1, 0, 1, OFF);
        step("L3h_4", 0, 1, 0, 1, ALL);
        step("L3h_5", 0, 0, 0, 0, OFF);
        step("R3h_0", 0, 0, 1, 0, ER1);
        step("R3h_1", 0, 0, 1, 0, ER2);
        step("R3h_2", 0, 0, 1, 0, ER3);
        step("R3h_3", 0, 0, 1, 1, OFF);
        step("R3h_4", 0, 0, 1, 1, ALL);
        step("R3h_5", 0, 0, 0, 0, OFF);

        // Once a left sequence starts, the opposite direction does not
        // divert it.
        step("lock_0", 0, 1, 0, 0, EL1);
        step("lock_1", 0, 0, 1, 0, EL2);
        step("lock_2", 0, 0, 1, 0, EL3);
        step("lock_3", 0, 0, 1, 0, OFF);
        step("lock_4", 0, 0, 1, 0, ER1);
        step("lock_5", 0, 0, 0, 0, ER2);
        step("lock_6", 0, 0, 0, 0, ER3);
        step("lock_7", 0, 0, 0, 0, OFF);

        // Clear in L2 aborts the sequence and holds the lamps off. Unknown
        // inputs during Clear must not matter.
        step("clr_0", 0, 1, 0, 0, EL1);
        step("clr_1", 0, 1, 0, 0, EL2);
        step("clr_2", 1, 1, 0, 1, OFF);
        step("clr_3", 1, 1, 1, 1, OFF);
        step("clr_4", 1, 1'bx, 1'bx, 1'bx, OFF);
        // After Clear is released, the first transition leaves IDLE.
        step("clr_5", 0, 0, 1, 0, ER1);
        step("clr_6", 0, 0, 0, 0, ER2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
